// File: rtl/pipe_regfile_sb.sv
// pipe_regfile_sb
//   General-register file with an integrated write scoreboard for the
//   pipelined CPU. It provides NRD combinational read ports to ID, with a
//   write-through bypass from WB. It accepts one WB write per cycle. For
//   each register it keeps a PW-bit count of issued writes that have not yet
//   retired. ID issue is stalled on a RAW hazard, or when one more write
//   would overflow a register's pending count.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high; clears registers, counts, error
//   rd_addr        read addresses, port i at [i*AW +: AW]
//   rd_data        read data (bypassed from WB), port i at [i*DATA_W +: DATA_W]
//   rd_busy        port i source still has an unresolved pending write
//   iss_valid      ID presents an instruction
//   iss_src_used   port i is a real source of the issuing instruction
//   iss_we         issuing instruction writes iss_dst
//   iss_dst        destination of the issuing instruction
//   stall          issue blocked this cycle (combinational, flush-independent)
//   wb_we          WB write enable
//   wb_addr        WB destination
//   wb_data        WB data
//   flush          squash all in-flight instructions: clears every count
//   err_underflow  sticky: a WB write hit a register whose count was 0
//   gr_flat        raw register state, reg k at [k*DATA_W +: DATA_W]
module pipe_regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 8,
  parameter int AW       = 3,
  parameter int NRD      = 2,
  parameter int PW       = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NRD*AW-1:0]      rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic                   iss_valid,
  input  logic [NRD-1:0]         iss_src_used,
  input  logic                   iss_we,
  input  logic [AW-1:0]          iss_dst,
  output logic                   stall,
  input  logic                   wb_we,
  input  logic [AW-1:0]          wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   flush,
  output logic                   err_underflow,
  output logic [NREG*DATA_W-1:0] gr_flat
);

  localparam logic [PW-1:0] CNT_ZERO = '0;
  localparam logic [PW-1:0] CNT_ONE  = PW'(1);
  localparam logic [PW-1:0] CNT_MAX  = '1;

  logic [DATA_W-1:0] r_gr  [NREG];
  logic [PW-1:0]     r_cnt [NREG];
  logic              r_err;

  logic w_ret;
  logic w_ret_on_dst;
  logic w_src_hazard;
  logic w_fire;
  logic w_wb_ok;

  // Register 0 is hard-wired to zero when ZERO_REG is set: it is never
  // written and never counted, so it can never be busy.
  function automatic logic writable(input logic [AW-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  // Read ports, hazard detection and issue/retire qualification
  always_comb begin
    rd_data      = '0;
    rd_busy      = '0;
    w_src_hazard = 1'b0;
    w_wb_ok      = wb_we & writable(wb_addr);
    w_ret        = w_wb_ok & (r_cnt[wb_addr] != CNT_ZERO);
    w_ret_on_dst = w_ret & (wb_addr == iss_dst);
    for (int i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] a;
      a = rd_addr[i*AW +: AW];
      if (w_wb_ok && (wb_addr == a))
        rd_data[i*DATA_W +: DATA_W] = wb_data;
      else
        rd_data[i*DATA_W +: DATA_W] = r_gr[a];
      // The last outstanding write retiring now is resolved via the bypass.
      rd_busy[i] = (r_cnt[a] != CNT_ZERO) &
                   ~((r_cnt[a] == CNT_ONE) & wb_we & (wb_addr == a));
      if (iss_src_used[i] && rd_busy[i])
        w_src_hazard = 1'b1;
    end
    // A retire to the same destination frees a slot in the same cycle.
    stall  = iss_valid & (w_src_hazard |
             (iss_we & (r_cnt[iss_dst] == CNT_MAX) & ~w_ret_on_dst));
    w_fire = iss_valid & iss_we & ~stall & ~flush & writable(iss_dst);
  end

  // State update: register write, sticky underflow, pending counts
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) begin
        r_gr[k]  <= '0;
        r_cnt[k] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      if (w_wb_ok) begin
        r_gr[wb_addr] <= wb_data;
        // A write with nothing pending (e.g. after a flush) is absorbed
        // and flagged; the count stays at zero.
        if (r_cnt[wb_addr] == CNT_ZERO)
          r_err <= 1'b1;
      end
      for (int k = 0; k < NREG; k++) begin
        if (flush) begin
          r_cnt[k] <= '0;
        end else begin
          case ({w_fire && (iss_dst == AW'(k)), w_ret && (wb_addr == AW'(k))})
            2'b10:   r_cnt[k] <= r_cnt[k] + CNT_ONE;
            2'b01:   r_cnt[k] <= r_cnt[k] - CNT_ONE;
            default: r_cnt[k] <= r_cnt[k];
          endcase
        end
      end
    end
  end

  assign err_underflow = r_err;

  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign gr_flat[k*DATA_W +: DATA_W] = r_gr[k];
  end

endmodule
